// File: rtl/control_unit.sv
// ============================================================================
// Module   : control_unit
// Brief    : Microcoded fetch/execute sequencer for the SAP-1.5 core.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       flag_zero,
    input  logic       flag_carry,
    output logic [2:0] step,
    output logic       halt,
    output logic       pc_inc,
    output logic       load_pc,
    output logic       oe_pc,
    output logic       load_mar,
    output logic       oe_ram,
    output logic       load_ram,
    output logic       load_ir,
    output logic       oe_ir,
    output logic       load_a,
    output logic       oe_a,
    output logic       load_b,
    output logic       oe_alu,
    output logic       alu_sub,
    output logic       load_flags,
    output logic       load_o
);

    localparam logic [3:0] C_OP_LDA = 4'h1;
    localparam logic [3:0] C_OP_ADD = 4'h2;
    localparam logic [3:0] C_OP_SUB = 4'h3;
    localparam logic [3:0] C_OP_STA = 4'h4;
    localparam logic [3:0] C_OP_LDI = 4'h5;
    localparam logic [3:0] C_OP_JMP = 4'h6;
    localparam logic [3:0] C_OP_JC  = 4'h7;
    localparam logic [3:0] C_OP_JZ  = 4'h8;
    localparam logic [3:0] C_OP_OUT = 4'hE;
    localparam logic [3:0] C_OP_HLT = 4'hF;

    // Encoding doubles as the visible step number; HALT reads back as 7.
    typedef enum logic [2:0] {
        S_T0   = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4,
        S_HALT = 3'd7
    } state_t;

    state_t r_state;
    logic   w_last;

    always_comb begin
        pc_inc     = 1'b0;
        load_pc    = 1'b0;
        oe_pc      = 1'b0;
        load_mar   = 1'b0;
        oe_ram     = 1'b0;
        load_ram   = 1'b0;
        load_ir    = 1'b0;
        oe_ir      = 1'b0;
        load_a     = 1'b0;
        oe_a       = 1'b0;
        load_b     = 1'b0;
        oe_alu     = 1'b0;
        alu_sub    = 1'b0;
        load_flags = 1'b0;
        load_o     = 1'b0;
        w_last     = 1'b0;
        // Reset masks every strobe so a partially executed step cannot commit.
        if (!reset) begin
            case (r_state)
                S_T0: begin
                    oe_pc    = 1'b1;
                    load_mar = 1'b1;
                end
                S_T1: begin
                    oe_ram  = 1'b1;
                    load_ir = 1'b1;
                    pc_inc  = 1'b1;
                end
                S_T2: begin
                    case (opcode)
                        C_OP_LDA, C_OP_ADD, C_OP_SUB, C_OP_STA: begin
                            oe_ir    = 1'b1;
                            load_mar = 1'b1;
                        end
                        C_OP_LDI: begin
                            oe_ir  = 1'b1;
                            load_a = 1'b1;
                            w_last = 1'b1;
                        end
                        C_OP_JMP: begin
                            oe_ir   = 1'b1;
                            load_pc = 1'b1;
                            w_last  = 1'b1;
                        end
                        C_OP_JC: begin
                            oe_ir   = 1'b1;
                            load_pc = flag_carry;
                            w_last  = 1'b1;
                        end
                        C_OP_JZ: begin
                            oe_ir   = 1'b1;
                            load_pc = flag_zero;
                            w_last  = 1'b1;
                        end
                        C_OP_OUT: begin
                            oe_a   = 1'b1;
                            load_o = 1'b1;
                            w_last = 1'b1;
                        end
                        default: w_last = 1'b1;
                    endcase
                end
                S_T3: begin
                    case (opcode)
                        C_OP_LDA: begin
                            oe_ram = 1'b1;
                            load_a = 1'b1;
                            w_last = 1'b1;
                        end
                        C_OP_ADD, C_OP_SUB: begin
                            oe_ram = 1'b1;
                            load_b = 1'b1;
                        end
                        C_OP_STA: begin
                            oe_a     = 1'b1;
                            load_ram = 1'b1;
                            w_last   = 1'b1;
                        end
                        default: w_last = 1'b1;
                    endcase
                end
                S_T4: begin
                    oe_alu     = 1'b1;
                    load_a     = 1'b1;
                    load_flags = 1'b1;
                    alu_sub    = (opcode == C_OP_SUB);
                    w_last     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_T0;
        end else begin
            case (r_state)
                S_T0:    r_state <= S_T1;
                S_T1:    r_state <= S_T2;
                S_T2:    r_state <= w_last ? ((opcode == C_OP_HLT) ? S_HALT : S_T0) : S_T3;
                S_T3:    r_state <= w_last ? S_T0 : S_T4;
                S_T4:    r_state <= S_T0;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_T0;
            endcase
        end
    end

    assign step = reset ? 3'd0 : r_state;
    assign halt = !reset && (r_state == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// Module   : tb_control_unit
// Brief    : Scoreboard bench for control_unit: expected microwords queued per cycle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_control_unit;

    // Strobe bit positions inside the 15-bit expected strobe word.
    localparam int C_PC_INC   = 14;
    localparam int C_LOAD_PC  = 13;
    localparam int C_OE_PC    = 12;
    localparam int C_LOAD_MAR = 11;
    localparam int C_OE_RAM   = 10;
    localparam int C_LOAD_RAM = 9;
    localparam int C_LOAD_IR  = 8;
    localparam int C_OE_IR    = 7;
    localparam int C_LOAD_A   = 6;
    localparam int C_OE_A     = 5;
    localparam int C_LOAD_B   = 4;
    localparam int C_OE_ALU   = 3;
    localparam int C_ALU_SUB  = 2;
    localparam int C_LOAD_FL  = 1;
    localparam int C_LOAD_O   = 0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic       flag_zero = 1'b0;
    logic       flag_carry = 1'b0;
    logic [2:0] step;
    logic       halt, pc_inc, load_pc, oe_pc, load_mar, oe_ram, load_ram, load_ir;
    logic       oe_ir, load_a, oe_a, load_b, oe_alu, alu_sub, load_flags, load_o;

    int         n_vec = 0;
    int         n_err = 0;
    logic [18:0] sb_q[$];

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .flag_zero(flag_zero), .flag_carry(flag_carry),
        .step(step), .halt(halt), .pc_inc(pc_inc), .load_pc(load_pc),
        .oe_pc(oe_pc), .load_mar(load_mar), .oe_ram(oe_ram), .load_ram(load_ram),
        .load_ir(load_ir), .oe_ir(oe_ir), .load_a(load_a), .oe_a(oe_a),
        .load_b(load_b), .oe_alu(oe_alu), .alu_sub(alu_sub),
        .load_flags(load_flags), .load_o(load_o)
    );

    function automatic logic [14:0] b(input int pos);
        return 15'(1) << pos;
    endfunction

    function automatic int inst_len(input logic [3:0] op);
        case (op)
            4'h1, 4'h4: return 4;
            4'h2, 4'h3: return 5;
            default:    return 3;
        endcase
    endfunction

    function automatic logic [14:0] exp_strobes(input logic [3:0] op, input int t,
                                                input logic fc, input logic fz);
        logic [14:0] s;
        s = '0;
        if (t == 0) s = b(C_OE_PC) | b(C_LOAD_MAR);
        else if (t == 1) s = b(C_OE_RAM) | b(C_LOAD_IR) | b(C_PC_INC);
        else if (t == 2) begin
            case (op)
                4'h1, 4'h2, 4'h3, 4'h4: s = b(C_OE_IR) | b(C_LOAD_MAR);
                4'h5: s = b(C_OE_IR) | b(C_LOAD_A);
                4'h6: s = b(C_OE_IR) | b(C_LOAD_PC);
                4'h7: s = b(C_OE_IR) | (fc ? b(C_LOAD_PC) : 15'd0);
                4'h8: s = b(C_OE_IR) | (fz ? b(C_LOAD_PC) : 15'd0);
                4'hE: s = b(C_OE_A) | b(C_LOAD_O);
                default: s = '0;
            endcase
        end else if (t == 3) begin
            case (op)
                4'h1:       s = b(C_OE_RAM) | b(C_LOAD_A);
                4'h2, 4'h3: s = b(C_OE_RAM) | b(C_LOAD_B);
                4'h4:       s = b(C_OE_A) | b(C_LOAD_RAM);
                default:    s = '0;
            endcase
        end else begin
            s = b(C_OE_ALU) | b(C_LOAD_A) | b(C_LOAD_FL) | ((op == 4'h3) ? b(C_ALU_SUB) : 15'd0);
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    // Sample on the falling edge, pop one expected vector, then step to just past posedge.
    task automatic sample_cycle(input string tag);
        logic [18:0] got;
        logic [18:0] exp;
        @(negedge clk);
        got = {step, halt, pc_inc, load_pc, oe_pc, load_mar, oe_ram, load_ram, load_ir,
               oe_ir, load_a, oe_a, load_b, oe_alu, alu_sub, load_flags, load_o};
        exp = sb_q.pop_front();
        check(tag, {13'd0, got}, {13'd0, exp});
        check("oe_excl", 32'($countones({oe_pc, oe_ram, oe_ir, oe_a, oe_alu}) <= 1), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // One instruction; rst_at >= 0 asserts reset during that step and aborts.
    task automatic run_instr(input string tag, input logic [3:0] op, input logic fc,
                             input logic fz, input int rst_at);
        for (int t = 0; t < inst_len(op); t++) begin
            opcode     = (t < 2) ? 4'($urandom_range(0, 15)) : op;
            flag_carry = (t < 2) ? 1'($urandom_range(0, 1)) : fc;
            flag_zero  = (t < 2) ? 1'($urandom_range(0, 1)) : fz;
            reset      = (t == rst_at);
            if (t == rst_at) sb_q.push_back(19'd0);
            else             sb_q.push_back({3'(t), 1'b0, exp_strobes(op, t, fc, fz)});
            sample_cycle(tag);
            if (t == rst_at) begin
                reset = 1'b0;
                return;
            end
        end
    endtask

    task automatic idle(input string tag, input int n, input logic rst, input logic [18:0] exp);
        for (int i = 0; i < n; i++) begin
            reset = rst;
            sb_q.push_back(exp);
            sample_cycle(tag);
        end
        reset = 1'b0;
    endtask

    localparam logic [18:0] C_HALT_VEC = {3'd7, 1'b1, 15'd0};

    initial begin
        int cyc;
        logic [3:0] op;
        #1;
        idle("reset", 3, 1'b1, 19'd0);
        run_instr("nop_fetch", 4'h0, 1'b0, 1'b0, -1);
        run_instr("add", 4'h2, 1'b0, 1'b0, -1);
        run_instr("sub", 4'h3, 1'b1, 1'b1, -1);
        run_instr("jc_c0", 4'h7, 1'b0, 1'b1, -1);
        run_instr("jc_c1", 4'h7, 1'b1, 1'b0, -1);
        run_instr("jz_z1", 4'h8, 1'b0, 1'b1, -1);
        run_instr("jz_z0", 4'h8, 1'b1, 1'b0, -1);
        run_instr("lda", 4'h1, 1'b0, 1'b0, -1);
        run_instr("sta", 4'h4, 1'b0, 1'b0, -1);
        run_instr("ldi", 4'h5, 1'b0, 1'b0, -1);
        run_instr("jmp", 4'h6, 1'b0, 1'b0, -1);
        run_instr("out", 4'hE, 1'b0, 1'b0, -1);
        run_instr("hlt", 4'hF, 1'b0, 1'b0, -1);
        idle("halted", 20, 1'b0, C_HALT_VEC);
        idle("halt_rst", 1, 1'b1, 19'd0);
        run_instr("post_halt", 4'h0, 1'b0, 1'b0, -1);
        run_instr("lda_rst", 4'h1, 1'b0, 1'b0, 3);
        run_instr("post_rst", 4'h5, 1'b0, 1'b0, -1);

        cyc = 0;
        while (cyc < 1000) begin
            op = 4'($urandom_range(0, 15));
            run_instr("rand", op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
            cyc += inst_len(op);
            if (op == 4'hF) begin
                idle("rand_halt", 2, 1'b0, C_HALT_VEC);
                idle("rand_rst", 1, 1'b1, 19'd0);
                cyc += 3;
            end
        end

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
